// File: rtl/axis_crc_pkg.sv
// Shared CRC-8 definitions for the AXI-Stream CRC append stage and the crc8 checker.
//   CRC8_POLY/CRC8_INIT/CRC8_XOROUT : default CRC-8 parameters (MSB-first, non-reflected)
//   crc8_next()                      : one-byte CRC update
//   crc_state_e                      : append-stage state encoding
package axis_crc_pkg;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam logic [7:0] CRC8_XOROUT = 8'h00;

  typedef enum logic [0:0] {
    S_DATA = 1'b0,
    S_CRC  = 1'b1
  } crc_state_e;

  // Fold one data byte into the CRC, MSB first.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_crc8_append.sv
// Byte-wide AXI-Stream stage that forwards each payload frame and, when enabled, appends a
// CRC-8 byte after the last payload beat, moving tlast onto that byte. Output is a register
// slice; no combinational path from s_axis_* to m_axis_*.
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   crc_en                 : append enable, sampled on the first accepted beat of a frame
//   s_axis_tdata/tvalid/tready/tlast : payload input
//   m_axis_tdata/tvalid/tready/tlast : payload + CRC output
//   frame_cnt              : frames emitted, wraps modulo 2^16
module axis_crc8_append
  import axis_crc_pkg::*;
#(
  parameter logic [7:0] POLY   = CRC8_POLY,
  parameter logic [7:0] INIT   = CRC8_INIT,
  parameter logic [7:0] XOROUT = CRC8_XOROUT
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        crc_en,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] frame_cnt
);

  crc_state_e  state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic        first_q, first_d;
  logic        app_q, app_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [15:0] cnt_q, cnt_d;

  logic slot_free;
  logic app_eff;

  assign slot_free     = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == S_DATA) && slot_free;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_cnt     = cnt_q;

  // The enable seen by this beat: fresh crc_en on a frame's first beat, latched value after.
  assign app_eff = first_q ? crc_en : app_q;

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    first_d  = first_q;
    app_d    = app_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    cnt_d    = cnt_q;

    if (slot_free) begin
      tvalid_d = 1'b0;
      unique case (state_q)
        S_DATA: begin
          if (s_axis_tvalid) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            app_d    = app_eff;
            first_d  = s_axis_tlast;
            crc_d    = crc8_next(crc_q, s_axis_tdata, POLY);
            tlast_d  = 1'b0;
            if (s_axis_tlast) begin
              if (app_eff) begin
                state_d = S_CRC;
              end else begin
                tlast_d = 1'b1;
                crc_d   = INIT;
                cnt_d   = cnt_q + 16'd1;
              end
            end
          end
        end
        S_CRC: begin
          tdata_d  = crc_q ^ XOROUT;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          crc_d    = INIT;
          cnt_d    = cnt_q + 16'd1;
          state_d  = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_DATA;
      crc_q    <= INIT;
      first_q  <= 1'b1;
      app_q    <= 1'b0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      first_q  <= first_d;
      app_q    <= app_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_crc8_append.sv
module tb_axis_crc8_append;

  localparam logic [7:0] POLY   = 8'h07;
  localparam logic [7:0] XOROUT = 8'h00;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        crc_en = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [15:0] frame_cnt;

  axis_crc8_append dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .crc_en        (crc_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_cnt     (frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass = 0;
  int exp_frames = 0;
  bit rand_ready = 1'b0;
  logic [8:0] exp_q[$];  // {tlast, tdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // CRC as remainder of the zero-augmented message divided by the generator (INIT = 0).
  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    logic [7:0] rem;
    int nbits;
    logic b;
    logic top;
    rem = 8'h00;
    nbits = msg.size() * 8 + 8;
    for (int i = 0; i < nbits; i++) begin
      if (i < msg.size() * 8) b = msg[i / 8][7 - (i % 8)];
      else b = 1'b0;
      top = rem[7];
      rem = {rem[6:0], b};
      if (top) rem = rem ^ POLY;
    end
    return rem ^ XOROUT;
  endfunction

  // Downstream ready: constant 1 or random 50%.
  always @(posedge aclk) begin
    #1;
    m_axis_tready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic       stalled = 1'b0;
  logic [8:0] held;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (stalled && m_axis_tvalid) check("stall_hold", {m_axis_tlast, m_axis_tdata}, held);
      if (stalled && !m_axis_tvalid) check("stall_valid_drop", m_axis_tvalid, 1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 9'h1ff);
        end else begin
          check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = {m_axis_tlast, m_axis_tdata};
    end else begin
      stalled = 1'b0;
    end
  end

  // Issue one frame; crc_en is presented as en on beat 0 and optionally flipped afterwards.
  task automatic send_frame(input logic [7:0] bytes[$], input bit en, input bit flip,
                            input bit complete);
    int wait_cyc;
    for (int i = 0; i < bytes.size(); i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bytes[i];
      s_axis_tlast  = complete && (i == bytes.size() - 1);
      crc_en        = (i > 0 && flip) ? ~en : en;
      wait_cyc = 0;
      @(negedge aclk);
      while (!s_axis_tready && wait_cyc < 200) begin
        wait_cyc++;
        @(negedge aclk);
      end
      if (!s_axis_tready) begin
        check("s_ready_timeout", 0, 1);
      end
      exp_q.push_back({1'b0, bytes[i]} | {(s_axis_tlast && !en), 8'h00});
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (complete) begin
      if (en) exp_q.push_back({1'b1, ref_crc(bytes)});
      exp_frames++;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && cyc < 500) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  logic [7:0] msg[$];
  logic [7:0] f1[$];

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_s_ready", s_axis_tready, 1);

    // "123456789" with CRC, downstream always ready
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("ref_check_value", ref_crc(msg), 8'hF4);
    send_frame(msg, 1'b1, 1'b0, 1'b1);
    drain();
    check("frame_cnt_1", frame_cnt, 32'(exp_frames[15:0]));

    // {01} then {01 00} back-to-back
    f1 = '{8'h01};
    send_frame(f1, 1'b1, 1'b0, 1'b1);
    f1 = '{8'h01, 8'h00};
    send_frame(f1, 1'b1, 1'b0, 1'b1);
    drain();
    check("frame_cnt_3", frame_cnt, 32'(exp_frames[15:0]));

    // "123456789" under random backpressure
    rand_ready = 1'b1;
    send_frame(msg, 1'b1, 1'b0, 1'b1);
    drain();

    // Pass-through, with crc_en flipped mid-frame (ignored), and the reverse
    f1 = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(f1, 1'b0, 1'b1, 1'b1);
    send_frame(f1, 1'b1, 1'b1, 1'b1);
    drain();

    // Random frames, random enable, random backpressure
    for (int k = 0; k < 20; k++) begin
      int len;
      len = $urandom_range(1, 12);
      f1 = {};
      for (int j = 0; j < len; j++) f1.push_back(8'($urandom));
      send_frame(f1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    check("frame_cnt_rand", frame_cnt, 32'(exp_frames[15:0]));
    rand_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset after 4 payload bytes
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(f1, 1'b1, 1'b0, 1'b0);
    drain();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    exp_q = {};
    exp_frames = 0;
    aresetn = 1'b1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    repeat (3) @(posedge aclk);
    #1;
    check("midrst_no_crc", m_axis_tvalid, 0);
    f1 = '{8'h01};
    send_frame(f1, 1'b1, 1'b0, 1'b1);
    drain();
    check("midrst_frame_cnt_1", frame_cnt, 32'(exp_frames[15:0]));

    // Counter wrap: reset, 65535 one-byte frames, then one more
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_frames = 0;
    @(posedge aclk);
    #1;
    f1 = '{8'h5A};
    for (int k = 0; k < 65535; k++) send_frame(f1, 1'b0, 1'b0, 1'b1);
    drain();
    check("frame_cnt_ffff", frame_cnt, 32'(exp_frames[15:0]));
    send_frame(f1, 1'b0, 1'b0, 1'b1);
    drain();
    check("frame_cnt_wrap", frame_cnt, 32'(exp_frames[15:0]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
